// File: rtl/core_interrupt_arbiter.sv
// Interrupt front end: latches external lines, filters them through the ICT and offers one IRQ at a time.
// Optional macro CORE_INTERRUPT_ARBITER_LEVEL_PRIORITY_EN selects level-based hardware priority.
module core_interrupt_arbiter #(
  parameter int NUM_EXT = 32,
  parameter int LEVEL_W = 2
) (
  input  logic               iCLOCK,
  input  logic               iRESET_SYNC,
  input  logic               iFREE_IRQ_SETCONDITION,
  input  logic               iICT_VALID,
  input  logic [5:0]         iICT_ENTRY,
  input  logic               iICT_CONF_MASK,
  input  logic               iICT_CONF_VALID,
  input  logic [LEVEL_W-1:0] iICT_CONF_LEVEL,
  input  logic [31:0]        iSYSREGINFO_PSR,
  input  logic [NUM_EXT-1:0] iEXT_REQ,
  output logic [NUM_EXT-1:0] oEXT_ACK,
  output logic [NUM_EXT-1:0] oEXT_PENDING,
  input  logic               iSWI_ACTIVE,
  input  logic [6:0]         iSWI_NUM,
  output logic               oSWI_ACK,
  input  logic               iEXCEPTION_LOCK,
  output logic               oEXCEPTION_ACTIVE,
  output logic [6:0]         oEXCEPTION_IRQ_NUM,
  input  logic               iEXCEPTION_IRQ_ACK
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  state_e             state_q, state_d;
  logic [NUM_EXT-1:0] req_q;
  logic [NUM_EXT-1:0] pending_q, pending_d;
  logic [NUM_EXT-1:0] mask_q, mask_d;
  logic [NUM_EXT-1:0] valid_q, valid_d;
  logic [LEVEL_W-1:0] level_q [NUM_EXT];
  logic [LEVEL_W-1:0] level_d [NUM_EXT];
  logic [6:0]         cap_num_q, cap_num_d;
  logic               cap_sw_q, cap_sw_d;
  logic [5:0]         cap_idx_q, cap_idx_d;

  logic [NUM_EXT-1:0] rise;
  logic [NUM_EXT-1:0] eligible;
  logic [NUM_EXT-1:0] ext_ack;
  logic               swi_ack;
  logic               active;
  logic [6:0]         irq_num;
  logic               gate;
  logic               hw_any;
  logic [5:0]         hw_idx;
  logic               unused_psr;

  assign rise       = iEXT_REQ & ~req_q;
  assign eligible   = pending_q & (~valid_q | mask_q);
  assign gate       = ~iEXCEPTION_LOCK & iSYSREGINFO_PSR[2];
  assign unused_psr = ^{iSYSREGINFO_PSR[31:3], iSYSREGINFO_PSR[1:0]};

`ifdef CORE_INTERRUPT_ARBITER_LEVEL_PRIORITY_EN
  logic [LEVEL_W-1:0] eff_lvl;
  logic [LEVEL_W-1:0] best_lvl;

  // Strict '>' keeps the first (lowest-index) line among equal levels.
  always_comb begin
    hw_any   = 1'b0;
    hw_idx   = '0;
    best_lvl = '0;
    eff_lvl  = '0;
    for (int n = 0; n < NUM_EXT; n++) begin
      eff_lvl = valid_q[n] ? level_q[n] : '0;
      if (eligible[n] && (!hw_any || eff_lvl > best_lvl)) begin
        hw_any   = 1'b1;
        hw_idx   = 6'(n);
        best_lvl = eff_lvl;
      end
    end
  end
`else
  logic unused_level;

  // Scan downwards so the lowest eligible index is the last one written.
  always_comb begin
    hw_any = 1'b0;
    hw_idx = '0;
    for (int n = NUM_EXT - 1; n >= 0; n--) begin
      if (eligible[n]) begin
        hw_any = 1'b1;
        hw_idx = 6'(n);
      end
    end
  end

  always_comb begin
    unused_level = 1'b0;
    for (int n = 0; n < NUM_EXT; n++) unused_level = unused_level ^ (^level_q[n]);
  end
`endif

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cap_num_d = cap_num_q;
    cap_sw_d  = cap_sw_q;
    cap_idx_d = cap_idx_q;
    mask_d    = mask_q;
    valid_d   = valid_q;
    level_d   = level_q;
    ext_ack   = '0;
    swi_ack   = 1'b0;
    active    = 1'b0;
    irq_num   = '0;

    // Entries beyond NUM_EXT never match, so those writes fall away.
    for (int n = 0; n < NUM_EXT; n++) begin
      if (iICT_VALID && iICT_ENTRY == 6'(n)) begin
        mask_d[n]  = iICT_CONF_MASK;
        valid_d[n] = iICT_CONF_VALID;
        level_d[n] = iICT_CONF_LEVEL;
      end
    end

    case (state_q)
      ST_IDLE: begin
        active = gate & (iSWI_ACTIVE | hw_any);
        if (active) begin
          irq_num   = iSWI_ACTIVE ? iSWI_NUM : {1'b0, hw_idx};
          state_d   = ST_WAIT;
          cap_num_d = irq_num;
          cap_sw_d  = iSWI_ACTIVE;
          cap_idx_d = hw_idx;
        end
      end
      ST_WAIT: begin
        active  = ~iFREE_IRQ_SETCONDITION;
        irq_num = cap_num_q;
        if (iEXCEPTION_IRQ_ACK) begin
          state_d = ST_IDLE;
          if (cap_sw_q) begin
            swi_ack = 1'b1;
          end else begin
            for (int n = 0; n < NUM_EXT; n++) ext_ack[n] = (cap_idx_q == 6'(n));
          end
        end else if (iFREE_IRQ_SETCONDITION) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A rise in the acknowledge cycle re-arms the line.
    pending_d = (pending_q & ~ext_ack) | rise;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      valid_q   <= '0;
      cap_num_q <= '0;
      cap_sw_q  <= 1'b0;
      cap_idx_q <= '0;
      // NOTE: the ICT is architecturally cleared by reset, so this small table is reset like plain flops.
      for (int n = 0; n < NUM_EXT; n++) level_q[n] <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= iEXT_REQ;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      valid_q   <= valid_d;
      level_q   <= level_d;
      cap_num_q <= cap_num_d;
      cap_sw_q  <= cap_sw_d;
      cap_idx_q <= cap_idx_d;
    end
  end

  // Outputs are held at zero while reset is asserted.
  assign oEXCEPTION_ACTIVE  = active & ~iRESET_SYNC;
  assign oEXCEPTION_IRQ_NUM = iRESET_SYNC ? '0 : irq_num;
  assign oEXT_ACK           = iRESET_SYNC ? '0 : ext_ack;
  assign oSWI_ACK           = swi_ack & ~iRESET_SYNC;
  assign oEXT_PENDING       = iRESET_SYNC ? '0 : pending_q;

endmodule

// File: tb/tb_core_interrupt_arbiter.sv
// Self-checking bench for core_interrupt_arbiter: directed table, corner sequences, random vs. reference model.
module tb_core_interrupt_arbiter;

  localparam int NUM = 32;

  typedef struct packed {
    logic        rst;
    logic [31:0] req;
    logic        swi;
    logic [6:0]  swi_num;
    logic        psr2;
    logic        lock;
    logic        ack;
    logic        free;
    logic        ict_we;
    logic [5:0]  ict_e;
    logic        ict_m;
    logic        ict_v;
    logic [1:0]  ict_l;
  } in_t;

  typedef struct packed {
    in_t         in;
    logic        e_act;
    logic [6:0]  e_num;
    logic [31:0] e_ext;
    logic        e_swi;
    logic [31:0] e_pend;
  } vec_t;

  logic             iCLOCK;
  logic             iRESET_SYNC;
  logic             iFREE_IRQ_SETCONDITION;
  logic             iICT_VALID;
  logic [5:0]       iICT_ENTRY;
  logic             iICT_CONF_MASK;
  logic             iICT_CONF_VALID;
  logic [1:0]       iICT_CONF_LEVEL;
  logic [31:0]      iSYSREGINFO_PSR;
  logic [NUM-1:0]   iEXT_REQ;
  logic [NUM-1:0]   oEXT_ACK;
  logic [NUM-1:0]   oEXT_PENDING;
  logic             iSWI_ACTIVE;
  logic [6:0]       iSWI_NUM;
  logic             oSWI_ACK;
  logic             iEXCEPTION_LOCK;
  logic             oEXCEPTION_ACTIVE;
  logic [6:0]       oEXCEPTION_IRQ_NUM;
  logic             iEXCEPTION_IRQ_ACK;

  core_interrupt_arbiter #(.NUM_EXT(NUM), .LEVEL_W(2)) dut (
    .iCLOCK                 (iCLOCK),
    .iRESET_SYNC            (iRESET_SYNC),
    .iFREE_IRQ_SETCONDITION (iFREE_IRQ_SETCONDITION),
    .iICT_VALID             (iICT_VALID),
    .iICT_ENTRY             (iICT_ENTRY),
    .iICT_CONF_MASK         (iICT_CONF_MASK),
    .iICT_CONF_VALID        (iICT_CONF_VALID),
    .iICT_CONF_LEVEL        (iICT_CONF_LEVEL),
    .iSYSREGINFO_PSR        (iSYSREGINFO_PSR),
    .iEXT_REQ               (iEXT_REQ),
    .oEXT_ACK               (oEXT_ACK),
    .oEXT_PENDING           (oEXT_PENDING),
    .iSWI_ACTIVE            (iSWI_ACTIVE),
    .iSWI_NUM               (iSWI_NUM),
    .oSWI_ACK               (oSWI_ACK),
    .iEXCEPTION_LOCK        (iEXCEPTION_LOCK),
    .oEXCEPTION_ACTIVE      (oEXCEPTION_ACTIVE),
    .oEXCEPTION_IRQ_NUM     (oEXCEPTION_IRQ_NUM),
    .iEXCEPTION_IRQ_ACK     (iEXCEPTION_IRQ_ACK)
  );

  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: per-line bits plus an "offered interrupt" record.
  bit          m_pend  [NUM];
  bit          m_prev  [NUM];
  bit          m_mask  [NUM];
  bit          m_valid [NUM];
  int          m_level [NUM];
  bit          m_busy;
  int          m_num;
  bit          m_sw;
  int          m_line;

  logic        exp_act;
  logic [6:0]  exp_num;
  logic [31:0] exp_ext;
  logic        exp_swi;
  logic [31:0] exp_pend;

`ifdef CORE_INTERRUPT_ARBITER_LEVEL_PRIORITY_EN
  localparam bit LVL_MODE = 1'b1;
`else
  localparam bit LVL_MODE = 1'b0;
`endif

  function automatic bit elig(int n);
    return m_pend[n] && (!m_valid[n] || m_mask[n]);
  endfunction

  // Winner: highest effective level first (in level mode), then lowest index.
  function automatic int pick();
    int best;
    best = 0;
    if (LVL_MODE) begin
      for (int n = 0; n < NUM; n++)
        if (elig(n) && m_valid[n] && m_level[n] > best) best = m_level[n];
    end
    for (int n = 0; n < NUM; n++) begin
      if (elig(n) && (!LVL_MODE || (m_valid[n] ? m_level[n] : 0) == best)) return n;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_eval(input in_t v);
    int w;
    exp_act = 1'b0; exp_num = '0; exp_ext = '0; exp_swi = 1'b0; exp_pend = '0;
    if (!v.rst) begin
      for (int n = 0; n < NUM; n++) exp_pend[n] = m_pend[n];
      if (!m_busy) begin
        w = pick();
        exp_act = v.psr2 && !v.lock && (v.swi || w >= 0);
        if (exp_act) exp_num = v.swi ? v.swi_num : 7'(w);
      end else begin
        exp_act = !v.free;
        exp_num = 7'(m_num);
        if (v.ack) begin
          if (m_sw) exp_swi = 1'b1;
          else exp_ext = 32'(1) << m_line;
        end
      end
    end
  endtask

  task automatic model_update(input in_t v);
    if (v.rst) begin
      for (int n = 0; n < NUM; n++) begin
        m_pend[n] = 0; m_prev[n] = 0; m_mask[n] = 0; m_valid[n] = 0; m_level[n] = 0;
      end
      m_busy = 0; m_num = 0; m_sw = 0; m_line = 0;
    end else begin
      if (m_busy && (v.ack || v.free)) m_busy = 0;
      else if (!m_busy && exp_act) begin
        m_busy = 1; m_num = int'(exp_num); m_sw = v.swi; m_line = int'(exp_num);
      end
      for (int n = 0; n < NUM; n++) begin
        if (exp_ext[n]) m_pend[n] = 0;
        if (v.req[n] && !m_prev[n]) m_pend[n] = 1;
        m_prev[n] = v.req[n];
      end
      if (v.ict_we && int'(v.ict_e) < NUM) begin
        m_mask[v.ict_e[4:0]]  = v.ict_m;
        m_valid[v.ict_e[4:0]] = v.ict_v;
        m_level[v.ict_e[4:0]] = int'(v.ict_l);
      end
    end
  endtask

  // Drive inputs shortly after a rising edge, let combinational outputs settle, evaluate the model.
  task automatic drive(input in_t v);
    iRESET_SYNC            = v.rst;
    iEXT_REQ               = v.req;
    iSWI_ACTIVE            = v.swi;
    iSWI_NUM               = v.swi_num;
    iSYSREGINFO_PSR        = {29'h0, v.psr2, 2'b00};
    iEXCEPTION_LOCK        = v.lock;
    iEXCEPTION_IRQ_ACK     = v.ack;
    iFREE_IRQ_SETCONDITION = v.free;
    iICT_VALID             = v.ict_we;
    iICT_ENTRY             = v.ict_e;
    iICT_CONF_MASK         = v.ict_m;
    iICT_CONF_VALID        = v.ict_v;
    iICT_CONF_LEVEL        = v.ict_l;
    #1;
    model_eval(v);
  endtask

  task automatic tick(input in_t v);
    @(posedge iCLOCK);
    model_update(v);
    #1;
  endtask

  function automatic in_t base();
    in_t v;
    v = '0;
    v.psr2 = 1'b1;
    return v;
  endfunction

  function automatic in_t ict(input logic [5:0] e, input logic m, input logic vld, input logic [1:0] l);
    in_t v;
    v = base();
    v.ict_we = 1'b1; v.ict_e = e; v.ict_m = m; v.ict_v = vld; v.ict_l = l;
    return v;
  endfunction

  function automatic vec_t mk(logic rst, logic [31:0] req, logic swi, logic [6:0] sn, logic psr2,
                              logic lock, logic ack, logic free, logic ea, logic [6:0] en,
                              logic [31:0] eext, logic eswi, logic [31:0] epend);
    vec_t t;
    t = '0;
    t.in = base();
    t.in.rst = rst; t.in.req = req; t.in.swi = swi; t.in.swi_num = sn; t.in.psr2 = psr2;
    t.in.lock = lock; t.in.ack = ack; t.in.free = free;
    t.e_act = ea; t.e_num = en; t.e_ext = eext; t.e_swi = eswi; t.e_pend = epend;
    return t;
  endfunction

  vec_t tbl [17];
  in_t  v;
  int   first_ln, second_ln;

  initial begin
    //            rst req      swi num   psr lck ack fre | act num   ext_ack  swi pending
    tbl[0]  = mk(1, 32'h0,    0, 7'h00, 1, 0, 0, 0,   0, 7'h00, 32'h0,   0, 32'h0);
    tbl[1]  = mk(0, 32'h20,   0, 7'h00, 1, 0, 0, 0,   0, 7'h00, 32'h0,   0, 32'h0);
    tbl[2]  = mk(0, 32'h0,    0, 7'h00, 1, 0, 1, 0,   1, 7'h05, 32'h0,   0, 32'h20);
    tbl[3]  = mk(0, 32'h0,    0, 7'h00, 1, 0, 1, 0,   1, 7'h05, 32'h20,  0, 32'h20);
    tbl[4]  = mk(0, 32'h0,    0, 7'h00, 1, 0, 0, 0,   0, 7'h00, 32'h0,   0, 32'h0);
    tbl[5]  = mk(0, 32'h08,   0, 7'h00, 1, 0, 0, 0,   0, 7'h00, 32'h0,   0, 32'h0);
    tbl[6]  = mk(0, 32'h0,    1, 7'h41, 1, 0, 0, 0,   1, 7'h41, 32'h0,   0, 32'h08);
    tbl[7]  = mk(0, 32'h0,    1, 7'h41, 1, 0, 1, 0,   1, 7'h41, 32'h0,   1, 32'h08);
    tbl[8]  = mk(0, 32'h0,    0, 7'h00, 1, 0, 0, 0,   1, 7'h03, 32'h0,   0, 32'h08);
    tbl[9]  = mk(0, 32'h0,    0, 7'h00, 1, 0, 1, 0,   1, 7'h03, 32'h08,  0, 32'h08);
    tbl[10] = mk(0, 32'h0,    0, 7'h00, 1, 0, 0, 0,   0, 7'h00, 32'h0,   0, 32'h0);
    tbl[11] = mk(0, 32'h80,   0, 7'h00, 1, 0, 0, 0,   0, 7'h00, 32'h0,   0, 32'h0);
    tbl[12] = mk(0, 32'h0,    0, 7'h00, 1, 1, 0, 0,   0, 7'h00, 32'h0,   0, 32'h80);
    tbl[13] = mk(0, 32'h0,    0, 7'h00, 0, 0, 0, 0,   0, 7'h00, 32'h0,   0, 32'h80);
    tbl[14] = mk(0, 32'h0,    0, 7'h00, 1, 0, 0, 0,   1, 7'h07, 32'h0,   0, 32'h80);
    tbl[15] = mk(0, 32'h0,    0, 7'h00, 1, 0, 1, 1,   0, 7'h07, 32'h80,  0, 32'h80);
    tbl[16] = mk(0, 32'h0,    0, 7'h00, 1, 0, 0, 0,   0, 7'h00, 32'h0,   0, 32'h0);

    v = base(); v.rst = 1'b1;
    drive(v); tick(v);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].in);
      check($sformatf("tbl%0d_active", i), 64'(oEXCEPTION_ACTIVE),  64'(tbl[i].e_act));
      check($sformatf("tbl%0d_num", i),    64'(oEXCEPTION_IRQ_NUM), 64'(tbl[i].e_num));
      check($sformatf("tbl%0d_ext_ack", i), 64'(oEXT_ACK),          64'(tbl[i].e_ext));
      check($sformatf("tbl%0d_swi_ack", i), 64'(oSWI_ACK),          64'(tbl[i].e_swi));
      check($sformatf("tbl%0d_pending", i), 64'(oEXT_PENDING),      64'(tbl[i].e_pend));
      tick(tbl[i].in);
    end

    // ICT mask: a valid, masked entry holds its line pending but never offers it.
    v = ict(6'd2, 1'b0, 1'b1, 2'd0); drive(v); tick(v);
    v = base(); v.req = 32'h4; drive(v); tick(v);
    v = base(); drive(v);
    check("ict_masked_active", 64'(oEXCEPTION_ACTIVE), 64'(0));
    check("ict_masked_pending", 64'(oEXT_PENDING), 64'(32'h4));
    tick(v);
    v = ict(6'd2, 1'b1, 1'b1, 2'd0); drive(v);
    check("ict_write_cycle_active", 64'(oEXCEPTION_ACTIVE), 64'(0));
    tick(v);
    v = base(); drive(v);
    check("ict_unmasked_active", 64'(oEXCEPTION_ACTIVE), 64'(1));
    check("ict_unmasked_num", 64'(oEXCEPTION_IRQ_NUM), 64'(7'h02));
    tick(v);
    v = base(); v.ack = 1'b1; drive(v);
    check("ict_ack", 64'(oEXT_ACK), 64'(32'h4));
    tick(v);
    v = ict(6'd40, 1'b0, 1'b1, 2'd0); drive(v); tick(v);  // out of range, ignored

    // Level priority: line 9 at level 3 beats line 1 at level 1 only in level mode.
    first_ln  = LVL_MODE ? 9 : 1;
    second_ln = LVL_MODE ? 1 : 9;
    v = ict(6'd9, 1'b1, 1'b1, 2'd3); drive(v); tick(v);
    v = ict(6'd1, 1'b1, 1'b1, 2'd1); drive(v); tick(v);
    v = base(); v.req = 32'h202; drive(v); tick(v);
    v = base(); drive(v);
    check("lvl_first_num", 64'(oEXCEPTION_IRQ_NUM), 64'(first_ln));
    tick(v);
    v = base(); v.ack = 1'b1; drive(v);
    check("lvl_first_ack", 64'(oEXT_ACK), 64'(32'(1) << first_ln));
    tick(v);
    v = base(); drive(v);
    check("lvl_second_num", 64'(oEXCEPTION_IRQ_NUM), 64'(second_ln));
    tick(v);
    v = base(); v.ack = 1'b1; drive(v); tick(v);

    // Frozen capture, then FREE withdraws the offer and the line is re-offered.
    v = base(); v.req = 32'h10; drive(v); tick(v);
    v = base(); drive(v);
    check("free_offer_num", 64'(oEXCEPTION_IRQ_NUM), 64'(7'h04));
    tick(v);
    v = base(); v.swi = 1'b1; v.swi_num = 7'h55; v.lock = 1'b1; drive(v);
    check("frozen_active", 64'(oEXCEPTION_ACTIVE), 64'(1));
    check("frozen_num", 64'(oEXCEPTION_IRQ_NUM), 64'(7'h04));
    tick(v);
    v = base(); v.free = 1'b1; drive(v);
    check("free_active", 64'(oEXCEPTION_ACTIVE), 64'(0));
    check("free_no_ack", 64'({oSWI_ACK, oEXT_ACK}), 64'(0));
    tick(v);
    v = base(); drive(v);
    check("free_pending_kept", 64'(oEXT_PENDING), 64'(32'h10));
    check("free_reoffer", 64'({oEXCEPTION_ACTIVE, oEXCEPTION_IRQ_NUM}), 64'({1'b1, 7'h04}));
    tick(v);
    v = base(); v.ack = 1'b1; drive(v);
    check("free_final_ack", 64'(oEXT_ACK), 64'(32'h10));
    tick(v);

    // Reset mid-WAIT, with line 10 held high through reset release.
    v = base(); v.req = 32'h40; drive(v); tick(v);
    v = base(); drive(v); tick(v);
    v = base(); v.rst = 1'b1; v.ack = 1'b1; v.req = 32'h400; drive(v);
    check("rst_outputs", 64'({oEXCEPTION_ACTIVE, oEXCEPTION_IRQ_NUM, oSWI_ACK}), 64'(0));
    check("rst_ext", 64'({oEXT_ACK, oEXT_PENDING}), 64'(0));
    tick(v);
    v = base(); v.req = 32'h400; drive(v);
    check("post_rst_pending", 64'(oEXT_PENDING), 64'(0));
    check("post_rst_active", 64'(oEXCEPTION_ACTIVE), 64'(0));
    tick(v);
    drive(v);
    check("held_rise_pending", 64'(oEXT_PENDING), 64'(32'h400));
    check("held_rise_num", 64'({oEXCEPTION_ACTIVE, oEXCEPTION_IRQ_NUM}), 64'({1'b1, 7'h0a}));
    tick(v);
    v.ack = 1'b1; drive(v);
    check("held_rise_ack", 64'(oEXT_ACK), 64'(32'h400));
    tick(v);

    // Random traffic against the reference model.
    v = base(); v.rst = 1'b1; drive(v); tick(v);
    v = base();
    for (int c = 0; c < 3000; c++) begin
      v.rst     = ($urandom_range(0, 199) == 0);
      v.req     = v.req ^ ($urandom & $urandom & $urandom);
      v.swi     = ($urandom_range(0, 7) == 0);
      v.swi_num = 7'($urandom);
      v.psr2    = ($urandom_range(0, 9) != 0);
      v.lock    = ($urandom_range(0, 9) == 0);
      v.ack     = ($urandom_range(0, 1) == 0);
      v.free    = ($urandom_range(0, 9) == 0);
      v.ict_we  = ($urandom_range(0, 5) == 0);
      v.ict_e   = 6'($urandom_range(0, 39));
      v.ict_m   = ($urandom_range(0, 3) != 0);
      v.ict_v   = ($urandom_range(0, 1) == 0);
      v.ict_l   = 2'($urandom);
      drive(v);
      check("rnd_active",  64'(oEXCEPTION_ACTIVE),  64'(exp_act));
      check("rnd_num",     64'(oEXCEPTION_IRQ_NUM), 64'(exp_num));
      check("rnd_ext_ack", 64'(oEXT_ACK),           64'(exp_ext));
      check("rnd_swi_ack", 64'(oSWI_ACK),           64'(exp_swi));
      check("rnd_pending", 64'(oEXT_PENDING),       64'(exp_pend));
      tick(v);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
